// File: rtl/safe_lock_top.sv
// 4-digit keypad safe controller: stores a passcode, then locks until that code is entered again.
// Latency: a keypress is registered 1 cycle after it is seen; lock changes on the clock after the 4th digit.
// Backpressure: none; keys that arrive during a message or lockout are dropped. Optional lockout: SAFE_LOCKOUT_EN.
module safe_lock_top #(
  parameter int MSG_CYCLES     = 10,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] key,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic        lock
);

  typedef enum logic [1:0] {ENTRY, MSG_OK, MSG_ERR, LOCKOUT} state_t;

  localparam int TMAX = (MSG_CYCLES > LOCKOUT_CYCLES) ? MSG_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_R     = 7'b0101111;
  localparam logic [6:0] G_O     = 7'b1000000;
  localparam logic [6:0] G_P     = 7'b0001100;
  localparam logic [6:0] G_N     = 7'b0101011;
  localparam logic [6:0] G_L     = 7'b1000111;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  state_t         state;
  logic [11:0]    key_q;
  logic [TW-1:0]  timer;
  logic [15:0]    code;
  logic [3:0]     ent [4];
  logic [2:0]     cnt;

`ifdef SAFE_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0]  fail_cnt;
`endif

  logic        press;
  logic [3:0]  digit;
  logic [15:0] nxt_code;

  function automatic logic [3:0] key_digit(input logic [11:0] k);
    key_digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) key_digit = 4'(i);
    end
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = G_DASH;
    endcase
  endfunction

  // Edge-detected, one-hot-only press qualification and the candidate 4-digit code
  always_comb begin
    press    = $onehot(key) && (key_q == 12'd0) && (state == ENTRY);
    digit    = key_digit(key);
    nxt_code = {ent[0], ent[1], ent[2], digit};
  end

  // Control FSM: entry buffer, stored code, lock, message/lockout timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ENTRY;
      key_q  <= '0;
      timer  <= '0;
      code   <= '0;
      lock   <= 1'b0;
      cnt    <= '0;
      for (int i = 0; i < 4; i++) ent[i] <= '0;
`ifdef SAFE_LOCKOUT_EN
      fail_cnt <= '0;
`endif
    end else begin
      // key_q tracks the keypad in every state so a key held through a message must be released
      key_q <= key;
      case (state)
        ENTRY: begin
          if (press) begin
            if (key[10]) begin
              cnt <= '0;
            end else if (|key[9:0]) begin
              if (cnt == 3'd3) begin
                cnt <= '0;
                if (!lock) begin
                  code <= nxt_code;
                  lock <= 1'b1;
                end else if (nxt_code == code) begin
                  state <= MSG_OK;
                  timer <= TW'(MSG_CYCLES);
`ifdef SAFE_LOCKOUT_EN
                  fail_cnt <= '0;
`endif
                end else begin
                  state <= MSG_ERR;
                  timer <= TW'(MSG_CYCLES);
`ifdef SAFE_LOCKOUT_EN
                  fail_cnt <= fail_cnt + 1'b1;
`endif
                end
              end else begin
                ent[cnt[1:0]] <= digit;
                cnt           <= cnt + 3'd1;
              end
            end
          end
        end
        MSG_OK: begin
          if (timer <= TW'(1)) begin
            state <= ENTRY;
            timer <= '0;
            lock  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        MSG_ERR: begin
          if (timer <= TW'(1)) begin
`ifdef SAFE_LOCKOUT_EN
            if (fail_cnt >= FW'(MAX_FAILS)) begin
              state <= LOCKOUT;
              timer <= TW'(LOCKOUT_CYCLES);
            end else begin
              state <= ENTRY;
              timer <= '0;
            end
`else
            state <= ENTRY;
            timer <= '0;
`endif
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCKOUT: begin
`ifdef SAFE_LOCKOUT_EN
          if (timer <= TW'(1)) begin
            state    <= ENTRY;
            timer    <= '0;
            fail_cnt <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
`else
          state <= ENTRY;
          timer <= '0;
`endif
        end
        default: state <= ENTRY;
      endcase
    end
  end

  // Display decode from registered state only; first digit entered sits leftmost
  always_comb begin
    seg3 = G_DASH;
    seg2 = G_DASH;
    seg1 = G_DASH;
    seg0 = G_DASH;
    case (state)
      ENTRY: begin
        if (cnt > 3'd0) seg3 = glyph(ent[0]);
        if (cnt > 3'd1) seg2 = glyph(ent[1]);
        if (cnt > 3'd2) seg1 = glyph(ent[2]);
      end
      MSG_OK: begin
        seg3 = G_O;
        seg2 = G_P;
        seg1 = G_E;
        seg0 = G_N;
      end
      MSG_ERR: begin
        seg3 = G_E;
        seg2 = G_R;
        seg1 = G_R;
        seg0 = G_BLANK;
      end
      LOCKOUT: begin
        seg3 = G_L;
        seg2 = G_O;
        seg1 = G_C;
        seg0 = G_BLANK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_safe_lock_top.sv
// Bench for safe_lock_top: directed scenarios then random keypad traffic, checked every cycle
// against a queue/integer model of the safe's rules.
`timescale 1ns/1ps
module tb_safe_lock_top;

  localparam int MSG_CYCLES     = 10;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 40;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};
  localparam logic [27:0] MSG_OPEN = {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
  localparam logic [27:0] MSG_ERR  = {7'b0000110, 7'b0101111, 7'b0101111, 7'b1111111};
  localparam logic [27:0] MSG_LOC  = {7'b1000111, 7'b1000000, 7'b1000110, 7'b1111111};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] key = '0;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic        lock;

  int n_checks = 0;
  int n_fail   = 0;

  safe_lock_top #(
    .MSG_CYCLES(MSG_CYCLES), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .lock(lock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = taking digits, 1 = "OPEn", 2 = "Err", 3 = "LOC"
  int          m_mode, m_rem, m_fails, m_code, m_lock, m_val;
  int          q[$];
  logic [11:0] m_prev;
  bit          m_press;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_rem = 0; m_fails = 0; m_code = 0; m_lock = 0;
      q.delete();
      m_prev = '0;
    end else begin
      m_press = ($countones(key) == 1) && (m_prev == 12'd0) && (m_mode == 0);
      m_prev  = key;
      if (m_mode != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_mode == 1) m_lock = 0;
          if (m_mode == 2) begin
            m_mode = 0;
`ifdef SAFE_LOCKOUT_EN
            if (m_fails >= MAX_FAILS) begin
              m_mode  = 3;
              m_rem   = LOCKOUT_CYCLES;
              m_fails = 0;
            end
`endif
          end else begin
            m_mode = 0;
          end
        end
      end else if (m_press) begin
        if (key[10]) begin
          q.delete();
        end else if (key[9:0] != 10'd0) begin
          q.push_back($clog2(key));
          if (q.size() == 4) begin
            m_val = q[0] * 1000 + q[1] * 100 + q[2] * 10 + q[3];
            q.delete();
            if (m_lock == 0) begin
              m_code = m_val;
              m_lock = 1;
            end else if (m_val == m_code) begin
              m_mode = 1; m_rem = MSG_CYCLES; m_fails = 0;
            end else begin
              m_mode = 2; m_rem = MSG_CYCLES; m_fails++;
            end
          end
        end
      end
    end
  end

  function automatic logic [27:0] exp_segs();
    logic [6:0] s [4];
    case (m_mode)
      1: return MSG_OPEN;
      2: return MSG_ERR;
      3: return MSG_LOC;
      default: begin
        for (int i = 0; i < 4; i++) s[i] = (i < q.size()) ? GLYPH[q[i]] : DASH;
        return {s[0], s[1], s[2], s[3]};
      end
    endcase
  endfunction

  // Every-cycle comparison, well away from the rising edge
  always @(negedge clk) begin
    check("lock", {27'd0, lock}, {27'd0, m_lock[0]});
    check("segs", {seg3, seg2, seg1, seg0}, exp_segs());
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [11:0] v, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #2;
      key = v;
    end
  endtask

  task automatic press(input int k, input int hold);
    drive(12'd1 << k, hold);
    drive(12'd0, 1);
  endtask

  task automatic enter_code(input int a, input int b, input int c, input int d);
    press(a, 2); press(b, 2); press(c, 2); press(d, 2);
  endtask

  task automatic reset_pulse(input int cycles);
    @(posedge clk); #2;
    rst_n = 1'b0;
    key   = '0;
    repeat (cycles) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int r, k, hold;
    reset_pulse(2);
    @(negedge clk);
    check("reset_lock", {27'd0, lock}, 28'd0);
    check("reset_segs", {seg3, seg2, seg1, seg0}, {DASH, DASH, DASH, DASH});

    // first entry becomes the code
    enter_code(1, 2, 3, 4);
    @(negedge clk);
    check("set_lock", {27'd0, lock}, 28'd1);
    check("set_segs", {seg3, seg2, seg1, seg0}, {DASH, DASH, DASH, DASH});

    // wrong code shows Err, stays locked
    enter_code(9, 9, 9, 9);
    @(negedge clk);
    check("err_msg", {seg3, seg2, seg1, seg0}, MSG_ERR);
    drive(12'd0, MSG_CYCLES + 2);
    @(negedge clk);
    check("err_lock", {27'd0, lock}, 28'd1);

    // right code, key pressed during OPEn is dropped
    enter_code(1, 2, 3, 4);
    press(5, 2);
    @(negedge clk);
    check("open_msg", {seg3, seg2, seg1, seg0}, MSG_OPEN);
    drive(12'd0, MSG_CYCLES + 2);
    @(negedge clk);
    check("open_lock", {27'd0, lock}, 28'd0);
    check("open_buf", {seg3, seg2, seg1, seg0}, {DASH, DASH, DASH, DASH});

    // new code overwrites the old one
    enter_code(4, 3, 2, 1);
    @(negedge clk);
    check("relock", {27'd0, lock}, 28'd1);
    enter_code(4, 3, 2, 1);
    drive(12'd0, MSG_CYCLES + 2);
    @(negedge clk);
    check("reunlock", {27'd0, lock}, 28'd0);

    // reset mid-entry, then held key counts once
    press(6, 1);
    reset_pulse(2);
    @(negedge clk);
    check("rst2_lock", {27'd0, lock}, 28'd0);
    enter_code(0, 0, 0, 1);
    @(negedge clk);
    check("rst2_set", {27'd0, lock}, 28'd1);
    press(7, 5);
    @(negedge clk);
    check("hold_once", {seg3, seg2, seg1, seg0}, {GLYPH[7], DASH, DASH, DASH});
    press(10, 1);

    // three wrong codes (lockout when enabled), keys pressed meanwhile, then correct code
    for (int t = 0; t < MAX_FAILS; t++) begin
      enter_code(5, 5, 5, 5);
      drive(12'd0, MSG_CYCLES + 2);
    end
`ifdef SAFE_LOCKOUT_EN
    @(negedge clk);
    check("loc_msg", {seg3, seg2, seg1, seg0}, MSG_LOC);
`endif
    for (int t = 0; t < 6; t++) press(t, 2);
    drive(12'd0, LOCKOUT_CYCLES + 2);
    enter_code(0, 0, 0, 1);
    drive(12'd0, MSG_CYCLES + 2);
    @(negedge clk);
    check("final_unlock", {27'd0, lock}, 28'd0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        reset_pulse($urandom_range(1, 3));
      end else if (r <= 2) begin
        drive(12'($urandom_range(0, 4095)) | 12'b000000000011, $urandom_range(1, 3));
        drive(12'd0, 1);
      end else if (r <= 5) begin
        enter_code((m_code / 1000) % 10, (m_code / 100) % 10, (m_code / 10) % 10, m_code % 10);
      end else begin
        k    = $urandom_range(0, 11);
        hold = $urandom_range(1, 3);
        drive(12'd1 << k, hold);
        drive(12'd0, $urandom_range(0, 2));
      end
    end
    drive(12'd0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
